// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants for the buffered UART transmitter.
//   UART_ADDR      : MMIO address the store path decodes to produce wr_en
//   UTX_IDLE..STOP : serialiser FSM state encodings
//   ENABLE/DISABLE : single-bit flag values
//   even_parity()  : parity bit sent in the optional PARITY slot
package uart_tx_buffered_pkg;

    localparam logic [31:0] UART_ADDR = 32'h1000_0000;

    localparam logic [2:0] UTX_IDLE   = 3'd0;
    localparam logic [2:0] UTX_START  = 3'd1;
    localparam logic [2:0] UTX_DATA   = 3'd2;
    localparam logic [2:0] UTX_PARITY = 3'd3;
    localparam logic [2:0] UTX_STOP   = 3'd4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Store-path / status bundle of the buffered UART transmitter.
//   wr_en, wr_data : one-cycle push of a byte (CPU side drives)
//   full, empty    : FIFO status
//   busy           : serialiser not idle
//   overflow       : sticky, a push was dropped
//   uart_tx        : serial line, idle high
// master = CPU / store stage, slave = transmitter.
interface uart_tx_buffered_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       uart_tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, busy, overflow, uart_tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, busy, overflow, uart_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata at the tail (ignored while full)
//   wdata    : byte to write
//   pop      : drop the head (ignored while empty)
//   rdata    : current head, combinational
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of entries, log2(DEPTH)+1 bits
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter on the CPU store path. Stored bytes are queued in a FIFO and
// serialised 8N1 (or 8E1) so back-to-back stores never stall the pipeline.
//   clk  : system clock
//   rst  : synchronous, active-high reset; aborts any frame and discards queued bytes
//   bus  : uart_tx_buffered_if.slave (wr_en, wr_data in; full, empty, busy, overflow, uart_tx out)
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_buffered_if.slave  bus
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        pop;
    logic        has_data;
    logic        bit_done;

    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic          tx_q,      tx_d;
    logic          ovf_q,     ovf_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q,  parity_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .wdata (bus.wr_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign has_data = (fifo_count != '0);
    assign bit_done = (cnt_q == '0);
    assign ovf_d    = ovf_q | (bus.wr_en & fifo_full);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            UTX_IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = CNT_LOAD;
                    tx_d    = 1'b0;
                    state_d = UTX_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rdata);
`endif
                end
            end
            UTX_START: begin
                if (bit_done) begin
                    cnt_d     = CNT_LOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = UTX_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UTX_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = UTX_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = UTX_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // Next bit comes from position 1 before the shift lands.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            UTX_PARITY: begin
                if (bit_done) begin
                    cnt_d   = CNT_LOAD;
                    tx_d    = 1'b1;
                    state_d = UTX_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            UTX_STOP: begin
                if (bit_done) begin
                    if (has_data) begin
                        // Chain straight into the next frame with no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        cnt_d   = CNT_LOAD;
                        tx_d    = 1'b0;
                        state_d = UTX_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rdata);
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = UTX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UTX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UTX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            ovf_q     <= DISABLE;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.uart_tx  = tx_q;
    assign bus.busy     = (state_q != UTX_IDLE);
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = ovf_q;

endmodule
